// File: rtl/cp0_vic.sv
// cp0_vic: coprocessor 0 with a vectored interrupt controller.
//
// Holds STATUS (IE, IM), CAUSE (IP), EPC and EBASE. It synchronises and
// edge-detects N_IRQ external lines, latches them as pending bits, and picks
// the lowest-index eligible channel. It redirects the core to
// EBASE + (channel << VEC_SHIFT), or to EPC on ERET.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   oper               0=NOP 1=MFC0 2=MTC0 3=ERET
//   addr_r / data_r    combinational CP0 register read
//   addr_w / data_w    CP0 register write (MTC0)
//   ir_en              MEM stage can take an interrupt this cycle
//   ir_in              asynchronous rising-edge interrupt lines
//   ret_addr           return address saved to EPC on dispatch
//   ir                 an eligible request exists
//   ir_valid           one-cycle pulse following a dispatch
//   ir_wait            eligible request held off by ir_en=0
//   ir_id              channel of the last dispatch
//   jump_en/jump_addr  registered one-cycle redirect
module cp0_vic #(
    parameter int          N_IRQ     = 4,
    parameter int          VEC_SHIFT = 4,
    parameter logic [31:0] EBASE_RST = 32'h0000_0100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       oper,
    input  logic [4:0]       addr_r,
    output logic [31:0]      data_r,
    input  logic [4:0]       addr_w,
    input  logic [31:0]      data_w,
    input  logic             ir_en,
    input  logic [N_IRQ-1:0] ir_in,
    input  logic [31:0]      ret_addr,
    output logic             ir,
    output logic             ir_valid,
    output logic             ir_wait,
    output logic [2:0]       ir_id,
    output logic             jump_en,
    output logic [31:0]      jump_addr
);

    localparam logic [1:0]  OP_MTC0    = 2'd2;
    localparam logic [1:0]  OP_ERET    = 2'd3;
    localparam logic [31:0] EBASE_MASK = ~((32'd1 << VEC_SHIFT) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_JUMP
    } state_t;

    state_t             state_q, state_d;
    logic [N_IRQ-1:0]   sync1_q, sync2_q, sync3_q;
    logic               ie_q, ie_d;
    logic [N_IRQ-1:0]   im_q, im_d;
    logic [N_IRQ-1:0]   ip_q, ip_d;
    logic [31:0]        epc_q, epc_d;
    logic [31:0]        ebase_q, ebase_d;
    logic               jump_en_q, jump_en_d;
    logic [31:0]        jump_addr_q, jump_addr_d;
    logic               ir_valid_q, ir_valid_d;
    logic [2:0]         ir_id_q, ir_id_d;

    logic [N_IRQ-1:0]   rise;
    logic [N_IRQ-1:0]   eligible;
    logic               any_elig;
    logic [2:0]         winner;
    logic [N_IRQ-1:0]   ip_w1c;
    logic [N_IRQ-1:0]   ip_ack;
    logic               do_disp;
    logic               do_eret;
    logic [31:0]        vec_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            ie_q        <= 1'b0;
            im_q        <= '0;
            ip_q        <= '0;
            epc_q       <= '0;
            ebase_q     <= EBASE_RST;
            jump_en_q   <= 1'b0;
            jump_addr_q <= '0;
            ir_valid_q  <= 1'b0;
            ir_id_q     <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= ir_in;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            ie_q        <= ie_d;
            im_q        <= im_d;
            ip_q        <= ip_d;
            epc_q       <= epc_d;
            ebase_q     <= ebase_d;
            jump_en_q   <= jump_en_d;
            jump_addr_q <= jump_addr_d;
            ir_valid_q  <= ir_valid_d;
            ir_id_q     <= ir_id_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ie_d        = ie_q;
        im_d        = im_q;
        epc_d       = epc_q;
        ebase_d     = ebase_q;
        jump_en_d   = 1'b0;
        jump_addr_d = jump_addr_q;
        ir_valid_d  = 1'b0;
        ir_id_d     = ir_id_q;
        ip_w1c      = '0;
        ip_ack      = '0;

        // Edge detect on the synchronised lines (third FF holds last level).
        rise     = sync2_q & ~sync3_q;
        eligible = {N_IRQ{ie_q}} & ip_q & im_q;
        any_elig = |eligible;

        // Fixed priority: scan downwards so the lowest index wins.
        winner = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = 3'(i);
        end
        vec_addr = ebase_q + ({29'd0, winner} << VEC_SHIFT);

        do_eret = (oper == OP_ERET) && (state_q != S_JUMP);
        do_disp = (oper != OP_ERET) && (state_q != S_JUMP) && ir_en && any_elig;

        if (oper == OP_MTC0) begin
            case (addr_w)
                5'd12: begin
                    ie_d = data_w[0];
                    im_d = data_w[N_IRQ+7:8];
                end
                5'd13:   ip_w1c  = data_w[N_IRQ+7:8];
                5'd14:   epc_d   = data_w;
                5'd15:   ebase_d = data_w & EBASE_MASK;
                default: ;
            endcase
        end

        // Dispatch overrides any same-cycle write to IE/EPC.
        if (do_disp) begin
            ip_ack      = N_IRQ'(1) << winner;
            epc_d       = ret_addr;
            ie_d        = 1'b0;
            ir_id_d     = winner;
            jump_addr_d = vec_addr;
            jump_en_d   = 1'b1;
            ir_valid_d  = 1'b1;
            state_d     = S_JUMP;
        end else if (do_eret) begin
            ie_d        = 1'b1;
            jump_addr_d = epc_q;
            jump_en_d   = 1'b1;
            state_d     = S_JUMP;
        end else begin
            case (state_q)
                S_JUMP:  state_d = S_IDLE;
                default: state_d = (any_elig && !ir_en) ? S_WAIT : S_IDLE;
            endcase
        end

        // A new edge beats a clear of the same bit in the same cycle.
        ip_d = (ip_q & ~ip_w1c & ~ip_ack) | rise;
    end

    always_comb begin
        data_r = '0;
        case (addr_r)
            5'd12: begin
                data_r[0]           = ie_q;
                data_r[N_IRQ+7:8]   = im_q;
            end
            5'd13:   data_r[N_IRQ+7:8] = ip_q;
            5'd14:   data_r = epc_q;
            5'd15:   data_r = ebase_q;
            default: ;
        endcase
    end

    assign ir        = any_elig;
    assign ir_wait   = (state_q == S_WAIT);
    assign ir_valid  = ir_valid_q;
    assign ir_id     = ir_id_q;
    assign jump_en   = jump_en_q;
    assign jump_addr = jump_addr_q;

endmodule

// File: doc/cp0_vic.md
Name: cp0_vic

Overview:
- Parametrised successor to the single-line CP0: coprocessor 0 with N_IRQ external interrupt channels, per-channel mask, latched pending bits, fixed priority and vectored dispatch.
- Sits beside the datapath and controller in mips_core. Reads CP0 registers in ID, writes them in EXE, and checks for interrupts in MEM.
- Drives the same jump_en/jump_addr redirect used for ERET.

Parameters:
- N_IRQ, 4, number of interrupt channels (1..8); channel 0 has the highest priority.
- VEC_SHIFT, 4, log2 of vector spacing in bytes; jump_addr = EBASE + (channel << VEC_SHIFT).
- EBASE_RST, 32'h0000_0100, reset value of EBASE.

Ports:
- clk  in  1  main clock.
- rst  in  1  synchronous reset, active-high.
- oper  in  2  0=NOP, 1=MFC0, 2=MTC0, 3=ERET; sampled at posedge.
- addr_r  in  5  CP0 read address.
- data_r  out  32  read data; combinational from addr_r.
- addr_w  in  5  CP0 write address.
- data_w  in  32  write data.
- ir_en  in  1  MEM stage may accept an interrupt this cycle.
- ir_in  in  N_IRQ  asynchronous external interrupt lines, rising-edge triggered.
- ret_addr  in  32  address saved to EPC on dispatch.
- ir  out  1  at least one eligible request exists (IE & |(IP & IM)).
- ir_valid  out  1  one-cycle pulse on the dispatch cycle.
- ir_wait  out  1  eligible request held off because ir_en=0.
- ir_id  out  3  channel of the last dispatch.
- jump_en  out  1  registered one-cycle redirect pulse.
- jump_addr  out  32  redirect target; valid while jump_en=1.

Behaviour:
- Register map:
  - 12 STATUS: bit0 IE; bits[N_IRQ+7:8] IM.
  - 13 CAUSE: bits[N_IRQ+7:8] IP, read-only but write-1-to-clear via MTC0; bits[6:2] ExcCode, always 0.
  - 14 EPC: read/write.
  - 15 EBASE: read/write; bits[VEC_SHIFT-1:0] forced 0.
  - All other addresses read 0; writes to them are ignored. Unimplemented bits read 0.
- MTC0 takes effect at the posedge where oper==2. MFC0 is purely combinational; there is no write-to-read bypass.
- Synchroniser: 2 FF per line, plus 1 FF for edge detect. ir_in rising before posedge k sets IP at posedge k+2; the bit is visible in CAUSE from cycle k+2 onward.
- IP set and W1C clear on the same bit in the same cycle: set wins.
- Eligible = IE & (IP & IM); the winner is the lowest eligible index.
- FSM states:
  - IDLE: stays while no eligible request exists.
  - WAIT: eligible request present and ir_en=0. ir_wait=1 in WAIT. Moves to DISPATCH-capable IDLE behaviour as soon as ir_en=1.
  - JUMP: lasts exactly 1 cycle, then returns to IDLE.
- Dispatch at a posedge where state is IDLE or WAIT, ir_en=1, an eligible request exists and oper!=ERET:
  - EPC <= ret_addr, IE <= 0, IP[winner] <= 0, ir_id <= winner.
  - jump_addr <= EBASE + (winner << VEC_SHIFT); jump_en <= 1; ir_valid <= 1 (both registered, high for the following cycle only).
  - Go to JUMP.
- ERET at a posedge where state != JUMP: IE <= 1, jump_addr <= EPC, jump_en <= 1, go to JUMP. ir_valid stays 0.
- ERET and eligible dispatch in the same cycle: ERET wins. The request stays pending and is dispatched after the JUMP cycle (tail-chain).
- Same-cycle MTC0 and dispatch: the write is applied first, then dispatch overrides IE (forced 0) and EPC (takes ret_addr).
- While in JUMP, no dispatch occurs and ERET is ignored.
- Arithmetic: the vector add is 32-bit unsigned modulo 2^32; no carry is reported.
- Reset values: STATUS=0, CAUSE=0, EPC=0, EBASE=EBASE_RST, synchroniser FFs=0, state=IDLE. All outputs 0 except data_r, which follows addr_r.
- Reset during JUMP: jump_en is 0 in the next cycle and pending bits are lost.

Test Plan (N_IRQ=4, VEC_SHIFT=4, EBASE_RST=0x100):
- Reset, then read 12/13/14/15 -> 0, 0, 0, 0x100; jump_en=ir=ir_valid=ir_wait=0.
- MTC0 STATUS=0x0F01; ir_in[2] rises before edge k; ir_en=1; ret_addr=0x40 -> CAUSE=0x400 at k+2; jump_en=1, jump_addr=0x120, ir_valid=1, ir_id=2 in cycle after k+3; then EPC=0x40, STATUS=0x0F00, CAUSE=0.
- ir_in[1] and ir_in[3] rise together -> channel 1 dispatched to 0x110. ERET -> jump_en with jump_addr=EPC and IE=1. Next cycle after JUMP, channel 3 dispatched to 0x130.
- Eligible request with ir_en=0 for 5 cycles -> ir=1, ir_wait=1, jump_en=0 throughout; raise ir_en -> dispatch at that edge, ir_wait=0.
- STATUS=0x0B01 (IM2=0), ir_in[2] edge -> CAUSE=0x400, ir=0, no jump; MTC0 CAUSE=0x400 -> CAUSE=0; a new edge arriving on the same cycle as the W1C -> CAUSE stays 0x400.
- ERET issued on the same edge an eligible request first exists -> jump_addr=EPC first; interrupt dispatch follows after the JUMP cycle. Assert rst during JUMP -> jump_en=0 next cycle, STATUS=0.
